// File: rtl/mop_tree_adder_pipe.sv
// Pipelined multi-operand binary tree adder: one register stage per tree level,
// per-vector signed/unsigned mode, valid/ready stream handshake with backpressure.
module mop_tree_adder_pipe #(
    parameter int NUM_OPS = 8,
    parameter int W       = 18,
    localparam int LEVELS = $clog2(NUM_OPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_OPS*W-1:0]    in_data,
    input  logic                    in_signed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W+LEVELS-1:0]     out_sum
);

    // Handshake: a stage transfer happens on an edge where valid && ready.
    // The whole pipe freezes only when a finished result is waiting on the
    // consumer (stall); bubbles otherwise advance like data.
    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int N  = NUM_OPS >> l;
        localparam int CW = W + l - 1;

        logic [CW-1:0]  child [2*N];
        logic           child_valid;
        logic           child_signed;
        logic [CW:0]    sum_d [N];
        logic [CW:0]    sum_q [N];
        logic           valid_d, valid_q;
        logic           sgn_d, sgn_q;

        if (l == 1) begin : g_src
            always_comb begin
                for (int k = 0; k < 2*N; k++) begin
                    child[k] = in_data[k*W +: W];
                end
            end
            assign child_valid  = in_valid;
            assign child_signed = in_signed;
        end else begin : g_src
            always_comb begin
                for (int k = 0; k < 2*N; k++) begin
                    child[k] = g_lvl[l-1].sum_q[k];
                end
            end
            assign child_valid  = g_lvl[l-1].valid_q;
            assign child_signed = g_lvl[l-1].sgn_q;
        end

        // Sums only load for a valid vector, so bubbles leave the adders' flops quiet.
        always_comb begin
            sum_d   = sum_q;
            valid_d = valid_q;
            sgn_d   = sgn_q;
            if (!stall) begin
                valid_d = child_valid;
                if (child_valid) begin
                    sgn_d = child_signed;
                    for (int k = 0; k < N; k++) begin
                        sum_d[k] = {child_signed & child[2*k][CW-1],   child[2*k]}
                                 + {child_signed & child[2*k+1][CW-1], child[2*k+1]};
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < N; k++) begin
                    sum_q[k] <= '0;
                end
                valid_q <= 1'b0;
                sgn_q   <= 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    sum_q[k] <= sum_d[k];
                end
                valid_q <= valid_d;
                sgn_q   <= sgn_d;
            end
        end
    end

    assign out_valid = g_lvl[LEVELS].valid_q;
    assign out_sum   = g_lvl[LEVELS].sum_q[0];

endmodule

// File: doc/mop_tree_adder_pipe.md
Name: mop_tree_adder_pipe

Overview:
- Parametrised, pipelined multi-operand binary tree adder. It sums NUM_OPS operands of W bits each, with one register stage per tree level.
- Successor to the fixed 18-bit two-operand ripple adder. It adds operand-count scaling, selectable signed/unsigned mode and a valid/ready stream handshake with backpressure.
- Sits between the operand-gathering logic and the result consumer in the multi-operand adder datapath.

Parameters:
- NUM_OPS, 8, number of operands; power of two, minimum 2.
- W, 18, width of each operand in bits.
- LEVELS, log2(NUM_OPS), localparam; number of tree levels, which is also the number of pipeline stages.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept the operand vector this cycle.
- in_data  in  NUM_OPS*W  operand k occupies bits [k*W +: W].
- in_signed  in  1  1 = operands are two's complement; 0 = unsigned. Sampled with in_data.
- out_valid  out  1  out_sum holds a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  W+LEVELS  full-precision sum; never overflows.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, all stage sum registers, all stage sign flags, out_valid and out_sum clear to 0 immediately.
  - in_ready is 1 while in reset-released idle.
- Tree structure:
  - Level L (L = 1..LEVELS) holds NUM_OPS/2^L partial sums of width W+L.
  - Each node adds two children from level L-1. Each child is first extended by 1 bit: sign extension if the stage's signed flag is 1, zero extension otherwise.
  - Level 0 is the raw in_data; it is not registered.
- Pipeline:
  - Each level is registered. A level's registers carry the partial sums, a valid bit and the signed flag of the vector they hold.
  - The signed flag travels with its data, so mixed-mode vectors in flight are each summed correctly.
- Latency:
  - A vector accepted at edge T (in_valid && in_ready) produces out_valid=1 after edge T+LEVELS-1. That is, out_valid is visible LEVELS cycles after the accepting cycle.
  - out_sum is the level-LEVELS register.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stall is 0, every stage advances one level on each edge. Bubbles (valid=0) advance as well.
  - When stall is 1, all stage registers hold, including out_sum and out_valid.
  - No bubble collapsing: a bubble ahead of the output still costs a cycle.
- Throughput: one vector per cycle while out_ready=1.
- Input dropping: in_valid=1 while in_ready=0 is not accepted. The source must hold in_data and in_signed stable.
- Output stability: when out_valid=1 and out_ready=0, out_sum must remain stable until the handshake completes.
- Simultaneous accept and drain:
  - When out_valid && out_ready && in_valid all hold in the same cycle, both transfers occur.
  - The pipeline advances with no loss or duplication.
- Empty stages: a stage with valid=0 keeps its sum registers unchanged (no toggling) to save energy. Its valid bit is 0.
- Reset mid-operation: all in-flight vectors are discarded. After release, the first out_valid comes only from vectors accepted after release.
- Arithmetic: the result equals the exact integer sum of the operands, interpreted per in_signed, represented in W+LEVELS bits (two's complement when signed). Overflow is impossible by construction.

Test Plan (NUM_OPS=8, W=18, LEVELS=3, out_sum 21 bits unless noted):
1. Unsigned full scale: all operands 18'h3FFFF, in_signed=0 -> out_sum=21'h1FFFF8, out_valid high 3 cycles after accept.
2. Sign mode: op0=18'h3FFFF, others 0. With in_signed=0 -> 21'h03FFFF. Sent the next cycle with in_signed=1 -> 21'h1FFFFF. Both results appear on consecutive cycles, showing the flag is tracked per vector.
3. Streaming: 4 back-to-back vectors with operand k = k+b for beat b=0..3, out_ready=1 -> out_sum 28, 36, 44, 52 on 4 consecutive cycles; in_ready stays 1.
4. Backpressure: stream 6 vectors, drop out_ready for 3 cycles once the first result is valid:
   - in_ready=0 during the stall.
   - out_sum is held.
   - All 6 sums are delivered in order with no loss or duplication.
5. Reset mid-flight: assert rst_n low with 2 vectors in the pipe ->
   - out_valid and out_sum go to 0 without waiting for a clock edge.
   - After release with in_valid=0 for 5 cycles, out_valid stays 0.
6. NUM_OPS=2, W=18: operands 18'h3FFFF and 18'h00001 unsigned -> 19-bit out_sum=19'h40000, 1 cycle after accept.
